// File: rtl/cdb_wb_arbiter.sv
// Write-back arbiter: selects one requester per cycle and registers it onto the CDB.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module cdb_wb_arbiter #(
  parameter int unsigned      NUM_REQ     = 4,
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      REG_W       = 5,
  parameter int unsigned      TAG_W       = 4,
  parameter logic [TAG_W-1:0] TAG_INVALID = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      cdb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*REG_W-1:0]  req_reg,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         wd,
  output logic [REG_W-1:0]          wr,
  output logic [TAG_W-1:0]          w_tag
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic              blocked;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] sel_data;
  logic [REG_W-1:0]  sel_reg;
  logic [TAG_W-1:0]  sel_tag;

  logic              vld_q,  vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]  reg_q,  reg_d;
  logic [TAG_W-1:0]  tag_q,  tag_d;

  assign blocked = rst | flush | cdb_stall;

`ifdef CDB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Scan starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!blocked) begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        idx = (32'(ptr_q) + off) % NUM_REQ;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!blocked) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && req_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(i);
        end
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    sel_reg  = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_reg  = req_reg[i*REG_W +: REG_W];
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // flush outranks stall; a stall freezes the beat and the pointer.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    reg_d  = reg_q;
    tag_d  = tag_q;
`ifdef CDB_ROUND_ROBIN_EN
    ptr_d  = ptr_q;
`endif
    if (flush) begin
      vld_d = 1'b0;
      tag_d = TAG_INVALID;
    end else if (cdb_stall) begin
      vld_d = vld_q;
    end else if (gnt_any) begin
      vld_d  = 1'b1;
      data_d = sel_data;
      reg_d  = sel_reg;
      tag_d  = sel_tag;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_d  = gnt_idx;
`endif
    end else begin
      vld_d = 1'b0;
      tag_d = TAG_INVALID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      reg_q  <= '0;
      tag_q  <= TAG_INVALID;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_q  <= PTR_W'(NUM_REQ - 1);
`endif
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      reg_q  <= reg_d;
      tag_q  <= tag_d;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_q  <= ptr_d;
`endif
    end
  end

  assign cdb_valid = vld_q;
  assign wd        = data_q;
  assign wr        = reg_q;
  assign w_tag     = tag_q;

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter: vector table plus hand sequences for reset, payload and async reset.
module tb_cdb_wb_arbiter;

  localparam logic [3:0] TAG_INV = 4'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        cdb_stall;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [19:0] req_reg;
  logic [15:0] req_tag;
  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [31:0] wd;
  logic [4:0]  wr;
  logic [3:0]  w_tag;

  logic [31:0] data_arr [4];
  logic [4:0]  reg_arr  [4];
  logic [3:0]  tag_arr  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fl;
    logic        st;
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    int unsigned exp_src;
  } vec_t;

  vec_t vt [17];

  cdb_wb_arbiter #(
    .NUM_REQ(4), .DATA_W(32), .REG_W(5), .TAG_W(4), .TAG_INVALID(TAG_INV)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .cdb_stall(cdb_stall),
    .req_valid(req_valid), .req_data(req_data), .req_reg(req_reg), .req_tag(req_tag),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .wd(wd), .wr(wr), .w_tag(w_tag)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_data[i*32 +: 32] = data_arr[i];
      req_reg[i*5 +: 5]    = reg_arr[i];
      req_tag[i*4 +: 4]    = tag_arr[i];
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_bus(input string nm, input logic ev, input int unsigned es);
    check({nm, "_vld"}, 64'(cdb_valid), 64'(ev));
    if (ev) begin
      check({nm, "_wd"},  64'(wd),    64'(data_arr[es]));
      check({nm, "_wr"},  64'(wr),    64'(reg_arr[es]));
      check({nm, "_tag"}, 64'(w_tag), 64'(tag_arr[es]));
    end else begin
      check({nm, "_tag"}, 64'(w_tag), 64'(TAG_INV));
    end
  endtask

  task automatic step(input string nm, input logic fl, input logic st, input logic [3:0] v,
                      input logic [3:0] er, input logic ev, input int unsigned es);
    @(negedge clk);
    flush = fl;
    cdb_stall = st;
    req_valid = v;
    #1;
    check({nm, "_ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    check_bus(nm, ev, es);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      data_arr[i] = 32'hA000_0000 | 32'(i * 17 + 1);
      reg_arr[i]  = 5'(i + 10);
      tag_arr[i]  = 4'(i + 1);
    end

    // Fixed-priority expectations; round-robin overrides follow.
    vt[0]  = '{1'b0, 1'b0, 4'hF, 4'h1, 1'b1, 0};
    for (int i = 1; i < 8; i++) vt[i] = vt[0];
    vt[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 0};
    vt[9]  = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b1, 2};
    vt[10] = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b1, 2};
    vt[11] = '{1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 2};
    vt[12] = '{1'b0, 1'b1, 4'h3, 4'h0, 1'b1, 2};
    vt[13] = '{1'b1, 1'b1, 4'h3, 4'h0, 1'b0, 0};
    vt[14] = '{1'b0, 1'b0, 4'h3, 4'h1, 1'b1, 0};
    vt[15] = '{1'b0, 1'b0, 4'h9, 4'h1, 1'b1, 0};
    vt[16] = '{1'b0, 1'b0, 4'h9, 4'h1, 1'b1, 0};
`ifdef CDB_ROUND_ROBIN_EN
    vt[1].exp_ready  = 4'h2; vt[1].exp_src  = 1;
    vt[2].exp_ready  = 4'h4; vt[2].exp_src  = 2;
    vt[3].exp_ready  = 4'h8; vt[3].exp_src  = 3;
    vt[5].exp_ready  = 4'h2; vt[5].exp_src  = 1;
    vt[6].exp_ready  = 4'h4; vt[6].exp_src  = 2;
    vt[7].exp_ready  = 4'h8; vt[7].exp_src  = 3;
    vt[15].exp_ready = 4'h8; vt[15].exp_src = 3;
`endif

    // T1: reset with every requester valid
    rst = 1'b1;
    flush = 1'b0;
    cdb_stall = 1'b0;
    req_valid = 4'hF;
    #2;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_vld",   64'(cdb_valid), 64'h0);
    check("rst_tag",   64'(w_tag),     64'(TAG_INV));
    check("rst_wd",    64'(wd),        64'h0);
    check("rst_wr",    64'(wr),        64'h0);
    @(negedge clk);
    req_valid = 4'h0;
    rst = 1'b0;

    for (int i = 0; i < 17; i++)
      step($sformatf("vec%0d", i), vt[i].fl, vt[i].st, vt[i].valid,
           vt[i].exp_ready, vt[i].exp_vld, vt[i].exp_src);

    // T2: single request with a specific payload, then idle
    data_arr[2] = 32'hDEADBEEF;
    reg_arr[2]  = 5'd7;
    tag_arr[2]  = 4'd3;
    @(negedge clk);
    flush = 1'b0;
    cdb_stall = 1'b0;
    req_valid = 4'h4;
    #1;
    check("t2_ready", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    check("t2_vld", 64'(cdb_valid), 64'h1);
    check("t2_wd",  64'(wd),        64'hDEADBEEF);
    check("t2_wr",  64'(wr),        64'd7);
    check("t2_tag", 64'(w_tag),     64'd3);
    step("t2_idle", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 0);

    // wr=0 passes through untouched
    reg_arr[1] = 5'd0;
    step("wr0", 1'b0, 1'b0, 4'h2, 4'h2, 1'b1, 1);

    // T6: asynchronous reset between edges while a beat is on the bus
    step("t6_beat", 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 0);
    #1;
    rst = 1'b1;
    #1;
    check("t6_vld",   64'(cdb_valid), 64'h0);
    check("t6_wd",    64'(wd),        64'h0);
    check("t6_wr",    64'(wr),        64'h0);
    check("t6_tag",   64'(w_tag),     64'(TAG_INV));
    check("t6_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_regrant", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    check_bus("t6_after", 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
